// File: rtl/dmem_stream_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_stream_ctrl
// Address/control sequencer for the Spiral NN Engine data-memory tile (DMem).
// It turns an upstream word stream and a downstream ready/valid consumer into
// a circular-buffer access pattern over a configurable DMem region. No data
// passes through this block; it only steers the tile.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cfg_vld           load configuration (only honoured while idle)
//   cfg_base/cfg_len  buffer region start address and length in words
//   cfg_src/cfg_dst   stream select: 0 = vertical, 1 = horizontal
//   in_valid/in_last  upstream word present / final word of the job
//   in_ready          controller accepts a word this cycle
//   out_valid         DMem read port holds a valid word
//   out_ready         downstream consumes the word this cycle
//   flush             abort the job and return to idle
//   we_ram, w_addr    DMem write enable and write address
//   r_addr            DMem read address
//   sel_ram_i/o       DMem input/output stream selects
//   count             words currently held in the buffer
//   busy              controller is not idle
// ---------------------------------------------------------------------------
module dmem_stream_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_vld,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_src,
  input  logic              cfg_dst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic              we_ram,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [1:0]        sel_ram_i,
  output logic [1:0]        sel_ram_o,
  output logic [ADDR_W:0]   count,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_L = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              src_q, src_d;
  logic              dst_q, dst_d;

  logic              pop;
  logic [ADDR_W:0]   last_addr;
  logic [ADDR_W-1:0] wp_next;
  logic [ADDR_W-1:0] rp_next;

  // Handshake and DMem control outputs, all derived from registered state.
  // flush suppresses both the write and the pop of its cycle.
  always_comb begin
    in_ready  = (state_q == ST_RUN) && (count_q < len_q);
    out_valid = (state_q != ST_IDLE) && (count_q != '0);
    we_ram    = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    w_addr    = wp_q;
    r_addr    = rp_q;
    busy      = (state_q != ST_IDLE);
    count     = count_q;
    sel_ram_i = (state_q != ST_IDLE) ? (src_q ? 2'b11 : 2'b10) : 2'b00;
    sel_ram_o = out_valid ? (dst_q ? 2'b11 : 2'b10) : 2'b00;
  end

  // Circular pointer advance; the end-of-region compare is one bit wider so
  // a region covering the whole memory (len = 2**ADDR_W) wraps correctly.
  always_comb begin
    last_addr = {1'b0, base_q} + len_q - ONE_L;
    wp_next   = ({1'b0, wp_q} == last_addr) ? base_q : wp_q + ONE_A;
    rp_next   = ({1'b0, rp_q} == last_addr) ? base_q : rp_q + ONE_A;
  end

  // Next-state logic: configuration capture, pointer/count bookkeeping and
  // the IDLE -> RUN -> DRAIN -> IDLE job sequence. flush overrides all.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    base_d  = base_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;

    if (flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      wp_d    = base_q;
      rp_d    = base_q;
    end else begin
      if (we_ram) wp_d = wp_next;
      if (pop)    rp_d = rp_next;
      if (we_ram && !pop)      count_d = count_q + ONE_L;
      else if (pop && !we_ram) count_d = count_q - ONE_L;

      case (state_q)
        ST_IDLE: begin
          if (cfg_vld) begin
            base_d  = cfg_base;
            len_d   = cfg_len;
            src_d   = cfg_src;
            dst_d   = cfg_dst;
            wp_d    = cfg_base;
            rp_d    = cfg_base;
            count_d = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (we_ram && in_last) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (count_d == '0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      base_q  <= '0;
      len_q   <= ONE_L;
      src_q   <= 1'b0;
      dst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      base_q  <= base_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

endmodule
